// File: rtl/disp_owner_sched.sv
// Display-ownership scheduler for the 8-digit seven-segment path: arbitrates KEY vs STAT,
// latches the owner's word once per scan frame and drives per-digit nibble/blank.
module disp_owner_sched #(
  parameter int SCAN_DIV    = 25000,
  parameter int IDLE_FRAMES = 1250
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        key_en_i,
  input  logic [3:0]  key_val_i,
  input  logic        key_clr_i,
  input  logic        stat_ld_i,
  input  logic [31:0] stat_word_i,
  output logic [31:0] disp_data_o,
  output logic        disp_owner_o,
  output logic [2:0]  dig_idx_o,
  output logic [3:0]  dig_nib_o,
  output logic        dig_blank_o,
  output logic        scan_tick_o
);

  localparam int SCAN_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int IDLE_W = (IDLE_FRAMES > 1) ? $clog2(IDLE_FRAMES) : 1;

  typedef enum logic {
    ST_STAT = 1'b0,
    ST_KEY  = 1'b1
  } owner_e;

  logic [SCAN_W-1:0] scan_cnt_q, scan_cnt_d;
  logic              scan_tick_q;
  logic [2:0]        dig_idx_q;

  logic [31:0]       key_buf_q, key_buf_d;
  logic [3:0]        key_cnt_q, key_cnt_d;
  logic [31:0]       stat_buf_q;

  owner_e            state_q, pending_q;
  logic [IDLE_W-1:0] idle_q;
  logic [31:0]       disp_data_q;
  logic [3:0]        disp_cnt_q;

  logic              key_strobe;
  logic              frame_end;

  assign key_strobe = key_en_i | key_clr_i;
  assign frame_end  = scan_tick_q & (dig_idx_q == 3'd7);

  always_comb begin
    scan_cnt_d = scan_cnt_q + SCAN_W'(1);
    if (scan_cnt_q == SCAN_W'(SCAN_DIV - 1)) begin
      scan_cnt_d = '0;
    end
  end

  // Tick is registered from the next counter value so it lines up with the last slot cycle.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      scan_cnt_q  <= '0;
      scan_tick_q <= 1'b0;
      dig_idx_q   <= '0;
    end else begin
      scan_cnt_q  <= scan_cnt_d;
      scan_tick_q <= (scan_cnt_d == SCAN_W'(SCAN_DIV - 1));
      if (scan_tick_q) begin
        dig_idx_q <= dig_idx_q + 3'd1;
      end
    end
  end

  // Clear beats a simultaneous entry; the count saturates at a full display.
  always_comb begin
    key_buf_d = key_buf_q;
    key_cnt_d = key_cnt_q;
    if (key_clr_i) begin
      key_buf_d = '0;
      key_cnt_d = '0;
    end else if (key_en_i) begin
      key_buf_d = {key_buf_q[27:0], key_val_i};
      if (key_cnt_q != 4'd8) begin
        key_cnt_d = key_cnt_q + 4'd1;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      key_buf_q  <= '0;
      key_cnt_q  <= '0;
      stat_buf_q <= '0;
    end else begin
      key_buf_q <= key_buf_d;
      key_cnt_q <= key_cnt_d;
      if (stat_ld_i) begin
        stat_buf_q <= stat_word_i;
      end
    end
  end

  // Ownership only moves at frame boundaries, using the pre-edge pending owner and buffers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= ST_STAT;
      pending_q   <= ST_STAT;
      idle_q      <= '0;
      disp_data_q <= '0;
      disp_cnt_q  <= '0;
    end else begin
      if (key_strobe) begin
        pending_q <= ST_KEY;
        idle_q    <= '0;
      end else if (frame_end && (state_q == ST_KEY)) begin
        if (idle_q == IDLE_W'(IDLE_FRAMES - 1)) begin
          pending_q <= ST_STAT;
          idle_q    <= '0;
        end else begin
          idle_q <= idle_q + IDLE_W'(1);
        end
      end
      if (frame_end) begin
        state_q     <= pending_q;
        disp_data_q <= (pending_q == ST_KEY) ? key_buf_q : stat_buf_q;
        disp_cnt_q  <= key_cnt_q;
      end
    end
  end

  assign disp_data_o  = disp_data_q;
  assign disp_owner_o = (state_q == ST_KEY);
  assign dig_idx_o    = dig_idx_q;
  assign scan_tick_o  = scan_tick_q;
  assign dig_nib_o    = disp_data_q[{dig_idx_q, 2'b00} +: 4];
  assign dig_blank_o  = disp_owner_o & ({1'b0, dig_idx_q} >= disp_cnt_q);

endmodule

// File: tb/tb_disp_owner_sched.sv
// Randomised bench for disp_owner_sched with a queue-based reference model of the
// key buffer, frame timing and display ownership.
module tb_disp_owner_sched;

  localparam int SCAN_DIV    = 4;
  localparam int IDLE_FRAMES = 2;
  localparam int FRAME       = 8 * SCAN_DIV;

  logic        clk = 1'b0;
  logic        rst;
  logic        keyEn, keyClr, statLd;
  logic [3:0]  keyVal;
  logic [31:0] statWord;
  logic [31:0] dispData;
  logic        dispOwner, digBlank, scanTick;
  logic [2:0]  digIdx;
  logic [3:0]  digNib;

  int nCompared   = 0;
  int nMismatched = 0;

  // Reference model state
  int          mT;
  logic [3:0]  mKeys[$];
  logic [31:0] mStat, mData;
  int          mDispCnt, mIdle;
  bit          mOwner, mPending;

  disp_owner_sched #(.SCAN_DIV(SCAN_DIV), .IDLE_FRAMES(IDLE_FRAMES)) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .key_en_i    (keyEn),
    .key_val_i   (keyVal),
    .key_clr_i   (keyClr),
    .stat_ld_i   (statLd),
    .stat_word_i (statWord),
    .disp_data_o (dispData),
    .disp_owner_o(dispOwner),
    .dig_idx_o   (digIdx),
    .dig_nib_o   (digNib),
    .dig_blank_o (digBlank),
    .scan_tick_o (scanTick)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nCompared++;
    if (got !== exp) begin
      nMismatched++;
      $display("[TB] FAIL %s: got %h expected %h (t=%0d)", tag, got, exp, mT);
    end
  endtask

  function automatic logic [31:0] keyWord();
    logic [31:0] w = 0;
    foreach (mKeys[i]) w = w * 16 + 32'(mKeys[i]);
    return w;
  endfunction

  function automatic void modelReset();
    mT = 0; mKeys.delete(); mStat = 0; mData = 0;
    mDispCnt = 0; mIdle = 0; mOwner = 0; mPending = 0;
  endfunction

  function automatic void modelEdge(bit en, logic [3:0] val, bit clr, bit ld, logic [31:0] word);
    bit          frameEnd = (mT % FRAME) == FRAME - 1;
    bit          snapPend = mPending;
    logic [31:0] snapKey  = keyWord();
    int          snapCnt  = mKeys.size();
    if (en || clr) begin
      mPending = 1; mIdle = 0;
    end else if (frameEnd && mOwner) begin
      mIdle++;
      if (mIdle == IDLE_FRAMES) begin mPending = 0; mIdle = 0; end
    end
    if (frameEnd) begin
      mOwner = snapPend; mData = snapPend ? snapKey : mStat; mDispCnt = snapCnt;
    end
    if (clr) mKeys.delete();
    else if (en) begin
      mKeys.push_back(val);
      if (mKeys.size() > 8) void'(mKeys.pop_front());
    end
    if (ld) mStat = word;
    mT++;
  endfunction

  task automatic checkAll();
    int idx = (mT / SCAN_DIV) % 8;
    checkOutput("data",  dispData,  mData);
    checkOutput("owner", 32'(dispOwner), 32'(mOwner));
    checkOutput("idx",   32'(digIdx),   32'(idx));
    checkOutput("tick",  32'(scanTick), 32'((mT % SCAN_DIV) == SCAN_DIV - 1));
    checkOutput("nib",   32'(digNib),   (mData >> (4 * idx)) & 32'hF);
    checkOutput("blank", 32'(digBlank), 32'(mOwner && (idx >= mDispCnt)));
  endtask

  task automatic applyStimulus(input bit en, input logic [3:0] val, input bit clr,
                               input bit ld, input logic [31:0] word);
    keyEn = en; keyVal = val; keyClr = clr; statLd = ld; statWord = word;
    @(posedge clk);
    modelEdge(en, val, clr, ld, word);
    #1;
    checkAll();
  endtask

  task automatic applyReset(input int n);
    rst = 1'b1; keyEn = 0; keyClr = 0; statLd = 0; keyVal = 0; statWord = 0;
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      modelReset();
      #1;
      checkAll();
    end
    rst = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) applyStimulus(0, 4'h0, 0, 0, 32'h0);
  endtask

  task automatic runToPhase(input int phase);
    for (int i = 0; i < FRAME && (mT % FRAME) != phase; i++) idle(1);
  endtask

  task automatic waitFrameEnd();
    idle(1);
    runToPhase(0);
  endtask

  initial begin
    rst = 1'b1;
    keyEn = 0; keyClr = 0; statLd = 0; keyVal = 0; statWord = 0;
    modelReset();

    applyReset(3);
    idle(40);

    applyStimulus(0, 4'h0, 0, 1, 32'h1234_5678);
    waitFrameEnd();
    checkOutput("s2_data",  dispData, 32'h1234_5678);
    checkOutput("s2_owner", 32'(dispOwner), 32'd0);
    checkOutput("s2_nib0",  32'(digNib), 32'h8);

    applyStimulus(1, 4'h3, 0, 0, 32'h0);
    applyStimulus(1, 4'h5, 0, 0, 32'h0);
    waitFrameEnd();
    checkOutput("s3_data",  dispData, 32'h0000_0035);
    checkOutput("s3_owner", 32'(dispOwner), 32'd1);
    checkOutput("s3_nib0",  32'(digNib), 32'h5);
    idle(SCAN_DIV);
    checkOutput("s3_nib1",  32'(digNib), 32'h3);
    idle(SCAN_DIV);
    checkOutput("s3_blank2", 32'(digBlank), 32'd1);

    for (int k = 1; k <= 9; k++) applyStimulus(1, 4'(k), 0, 0, 32'h0);
    waitFrameEnd();
    checkOutput("s4_data",   dispData, 32'h2345_6789);
    checkOutput("s4_blank0", 32'(digBlank), 32'd0);

    applyStimulus(1, 4'hA, 1, 0, 32'h0);
    waitFrameEnd();
    checkOutput("s5_data",   dispData, 32'h0);
    checkOutput("s5_owner",  32'(dispOwner), 32'd1);
    checkOutput("s5_blank0", 32'(digBlank), 32'd1);

    waitFrameEnd();
    checkOutput("s6_owner_hold", 32'(dispOwner), 32'd1);
    waitFrameEnd();
    checkOutput("s6_owner_stat", 32'(dispOwner), 32'd0);
    checkOutput("s6_data",       dispData, 32'h1234_5678);

    applyStimulus(1, 4'h7, 0, 0, 32'h0);
    waitFrameEnd();
    waitFrameEnd();
    runToPhase(FRAME - 1);
    applyStimulus(1, 4'h4, 0, 0, 32'h0);
    waitFrameEnd();
    checkOutput("s6_expiry_keep", 32'(dispOwner), 32'd1);

    for (int seg = 0; seg < 20; seg++) begin
      bit quiet = ($urandom_range(0, 1) == 1);
      int len   = $urandom_range(20, 160);
      for (int c = 0; c < len; c++) begin
        applyStimulus(!quiet && ($urandom_range(0, 5) == 0), 4'($urandom),
                      !quiet && ($urandom_range(0, 40) == 0),
                      ($urandom_range(0, 24) == 0), $urandom);
      end
    end

    runToPhase(13);
    applyReset(2);
    checkOutput("midrst_idx", 32'(digIdx), 32'd0);
    idle(2 * FRAME);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule
